// File: rtl/slot_payout_engine.sv
// Slot-machine payout stage: classifies a latched spin reel by reel, pays the
// bet-dependent prize into the player score and maintains the progressive jackpot pool.
module slot_payout_engine #(
    parameter int NUM_REELS     = 3,
    parameter int SYM_W         = 4,
    parameter int SCORE_W       = 17,
    parameter int JACKPOT_SYM   = 7,
    parameter int WIN_SINGLE    = 200,
    parameter int WIN_MAX       = 1000,
    parameter int PAIR_SINGLE   = 20,
    parameter int PAIR_MAX      = 100,
    parameter int JP_SEED       = 5000,
    parameter int JP_INC_SINGLE = 10,
    parameter int JP_INC_MAX    = 50
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [NUM_REELS*SYM_W-1:0] spin_in,
    input  logic                       bet_max,
    input  logic [SCORE_W-1:0]         score_in,
    output logic                       busy,
    output logic                       done,
    output logic [SCORE_W-1:0]         score_out,
    output logic [1:0]                 spin_type,
    output logic [SCORE_W-1:0]         jackpot_pool
);
    localparam int IDX_W = $clog2(NUM_REELS);
    localparam logic [IDX_W-1:0]   IDX_FIRST   = IDX_W'(1);
    localparam logic [IDX_W-1:0]   IDX_LAST    = IDX_W'(NUM_REELS - 1);
    localparam logic [SYM_W-1:0]   JP_SYMBOL   = SYM_W'(JACKPOT_SYM);
    localparam logic [SCORE_W-1:0] WIN_S       = SCORE_W'(WIN_SINGLE);
    localparam logic [SCORE_W-1:0] WIN_M       = SCORE_W'(WIN_MAX);
    localparam logic [SCORE_W-1:0] PAIR_S      = SCORE_W'(PAIR_SINGLE);
    localparam logic [SCORE_W-1:0] PAIR_M      = SCORE_W'(PAIR_MAX);
    localparam logic [SCORE_W-1:0] SEED        = SCORE_W'(JP_SEED);
    localparam logic [SCORE_W-1:0] INC_S       = SCORE_W'(JP_INC_SINGLE);
    localparam logic [SCORE_W-1:0] INC_M       = SCORE_W'(JP_INC_MAX);

    typedef enum logic [1:0] {IDLE, CHECK, PAY} stateT;

    stateT                      state, stateNext;
    logic [NUM_REELS*SYM_W-1:0] spinLatched, spinLatchedNext;
    logic                       betLatched, betLatchedNext;
    logic [SCORE_W-1:0]         scoreLatched, scoreLatchedNext;
    logic                       allMatch, allMatchNext;
    logic                       pairMatch, pairMatchNext;
    logic [IDX_W-1:0]           reelIdx, reelIdxNext;
    logic                       busyNext, doneNext;
    logic [SCORE_W-1:0]         scoreOutNext, poolNext;
    logic [1:0]                 spinTypeNext;

    // Reel 0 sits in the most significant field of the spin word.
    logic [SYM_W-1:0] reels [NUM_REELS];
    generate
        for (genvar gi = 0; gi < NUM_REELS; gi++) begin : g_reel
            assign reels[gi] = spinLatched[(NUM_REELS-1-gi)*SYM_W +: SYM_W];
        end
    endgenerate

    logic               isJackpot;
    logic [1:0]         typeCode;
    logic [SCORE_W-1:0] payout;
    logic [SCORE_W:0]   scoreSum, poolSum;

    always_comb begin
        isJackpot = allMatch && (reels[0] == JP_SYMBOL);
        typeCode  = 2'b00;
        payout    = '0;
        if (isJackpot) begin
            typeCode = 2'b11;
            payout   = jackpot_pool;
        end else if (allMatch) begin
            typeCode = 2'b01;
            payout   = betLatched ? WIN_M : WIN_S;
        end else if (pairMatch) begin
            typeCode = 2'b10;
            payout   = betLatched ? PAIR_M : PAIR_S;
        end
        scoreSum = {1'b0, scoreLatched} + {1'b0, payout};
        poolSum  = {1'b0, jackpot_pool} + {1'b0, (betLatched ? INC_M : INC_S)};
    end

    always_comb begin
        stateNext        = state;
        spinLatchedNext  = spinLatched;
        betLatchedNext   = betLatched;
        scoreLatchedNext = scoreLatched;
        allMatchNext     = allMatch;
        pairMatchNext    = pairMatch;
        reelIdxNext      = reelIdx;
        busyNext         = busy;
        doneNext         = 1'b0;
        scoreOutNext     = score_out;
        spinTypeNext     = spin_type;
        poolNext         = jackpot_pool;
        unique case (state)
            IDLE: begin
                if (start) begin
                    spinLatchedNext  = spin_in;
                    betLatchedNext   = bet_max;
                    scoreLatchedNext = score_in;
                    allMatchNext     = 1'b1;
                    reelIdxNext      = IDX_FIRST;
                    busyNext         = 1'b1;
                    stateNext        = CHECK;
                end
            end
            CHECK: begin
                if (reels[reelIdx] != reels[0]) allMatchNext = 1'b0;
                if (reelIdx == IDX_FIRST) pairMatchNext = (reels[1] == reels[0]);
                if (reelIdx == IDX_LAST) stateNext = PAY;
                else reelIdxNext = reelIdx + IDX_W'(1);
            end
            PAY: begin
                scoreOutNext = scoreSum[SCORE_W] ? '1 : scoreSum[SCORE_W-1:0];
                spinTypeNext = typeCode;
                // The jackpot pays the pool as it stood before this spin, then re-seeds.
                if (isJackpot) poolNext = SEED;
                else poolNext = poolSum[SCORE_W] ? '1 : poolSum[SCORE_W-1:0];
                doneNext  = 1'b1;
                busyNext  = 1'b0;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            spinLatched  <= '0;
            betLatched   <= 1'b0;
            scoreLatched <= '0;
            allMatch     <= 1'b0;
            pairMatch    <= 1'b0;
            reelIdx      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            score_out    <= '0;
            spin_type    <= 2'b00;
            jackpot_pool <= SEED;
        end else begin
            state        <= stateNext;
            spinLatched  <= spinLatchedNext;
            betLatched   <= betLatchedNext;
            scoreLatched <= scoreLatchedNext;
            allMatch     <= allMatchNext;
            pairMatch    <= pairMatchNext;
            reelIdx      <= reelIdxNext;
            busy         <= busyNext;
            done         <= doneNext;
            score_out    <= scoreOutNext;
            spin_type    <= spinTypeNext;
            jackpot_pool <= poolNext;
        end
    end
endmodule

// File: tb/tb_slot_payout_engine.sv
// Directed self-checking bench for slot_payout_engine with default parameters.
module tb_slot_payout_engine;
    logic        clk = 1'b0;
    logic        reset, start, bet_max;
    logic [11:0] spin_in;
    logic [16:0] score_in;
    logic        busy, done;
    logic [16:0] score_out, jackpot_pool;
    logic [1:0]  spin_type;

    int checkCount = 0;
    int passCount  = 0;

    slot_payout_engine dut (
        .clk(clk), .reset(reset), .start(start), .spin_in(spin_in),
        .bet_max(bet_max), .score_in(score_in), .busy(busy), .done(done),
        .score_out(score_out), .spin_type(spin_type), .jackpot_pool(jackpot_pool)
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Called just after a falling edge; inputs are scrambled right after acceptance.
    task automatic doSpin(input string tag, input logic [11:0] spin, input logic bet,
                          input logic [16:0] score, input int expScore, input int expType,
                          input int expPool);
        int cyc;
        spin_in = spin; bet_max = bet; score_in = score; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0; spin_in = ~spin; bet_max = ~bet; score_in = ~score;
        checkValue({tag, " busy"}, 32'(busy), 1);
        cyc = 1;
        while (!done && cyc < 10) begin
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        checkValue({tag, " latency"}, cyc, 4);
        checkValue({tag, " busy_at_done"}, 32'(busy), 0);
        checkValue({tag, " score"}, 32'(score_out), expScore);
        checkValue({tag, " type"}, 32'(spin_type), expType);
        checkValue({tag, " pool"}, 32'(jackpot_pool), expPool);
        $display("spin %s: spin=%h bet=%0d score_in=%0d -> score=%0d type=%b pool=%0d",
                 tag, spin, bet, score, score_out, spin_type, jackpot_pool);
        @(posedge clk); @(negedge clk);
        checkValue({tag, " done_clear"}, 32'(done), 0);
    endtask

    // Start held high for nSpins back-to-back spins; returns the number of done pulses.
    task automatic runHeld(input int nSpins, output int dones, output logic [11:0] pattern);
        dones = 0; pattern = '0;
        start = 1'b1;
        for (int i = 0; i < nSpins * 4; i++) begin
            @(posedge clk); @(negedge clk);
            if (i == nSpins * 4 - 1) start = 1'b0;
            if (done) dones++;
            if (i < 12) pattern[i] = done;
        end
    endtask

    initial begin
        int dones;
        logic [11:0] pattern;
        reset = 1'b0; start = 1'b0; spin_in = '0; bet_max = 1'b0; score_in = '0;

        #3 reset = 1'b1;
        #1;
        checkValue("reset busy", 32'(busy), 0);
        checkValue("reset done", 32'(done), 0);
        checkValue("reset score", 32'(score_out), 0);
        checkValue("reset type", 32'(spin_type), 0);
        checkValue("reset pool", 32'(jackpot_pool), 5000);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        doSpin("win_single",  12'h333, 1'b0, 17'd12,     212,    1, 5010);
        doSpin("jackpot",     12'h777, 1'b1, 17'd12,     5022,   3, 5000);
        doSpin("win_max",     12'h000, 1'b1, 17'd12,     1012,   1, 5050);
        doSpin("pair_max",    12'h552, 1'b1, 17'd0,      100,    2, 5100);
        doSpin("nothing",     12'h525, 1'b1, 17'd33,     33,     0, 5150);
        doSpin("score_sat",   12'h444, 1'b1, 17'd131000, 131071, 1, 5200);
        doSpin("pair_single", 12'h991, 1'b0, 17'd5,      25,     2, 5210);

        // Extra start pulses during CHECK must not launch a second spin.
        spin_in = 12'h123; bet_max = 1'b0; score_in = 17'd7; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        start = 1'b1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); @(negedge clk);
            if (i == 1) start = 1'b0;
            if (done) dones++;
        end
        checkValue("busy_ignore dones", dones, 1);
        checkValue("busy_ignore score", 32'(score_out), 7);
        checkValue("busy_ignore pool", 32'(jackpot_pool), 5220);
        $display("spin busy_ignore: dones=%0d score=%0d pool=%0d", dones, score_out, jackpot_pool);

        // Held start: the done cycle accepts the next spin, so done recurs every 4 cycles.
        spin_in = 12'h111; bet_max = 1'b0; score_in = 17'd0;
        runHeld(3, dones, pattern);
        checkValue("held dones", dones, 3);
        checkValue("held pattern", 32'(pattern), 32'h888);
        checkValue("held score", 32'(score_out), 200);
        checkValue("held pool", 32'(jackpot_pool), 5250);
        $display("spin held: dones=%0d pattern=%b pool=%0d", dones, pattern, jackpot_pool);

        // Reset during CHECK aborts the spin.
        spin_in = 12'h777; bet_max = 1'b1; score_in = 17'd0; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkValue("abort pool", 32'(jackpot_pool), 5000);
        checkValue("abort busy", 32'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); @(negedge clk);
            if (done) dones++;
        end
        checkValue("abort dones", dones, 0);
        checkValue("abort score", 32'(score_out), 0);
        $display("spin abort: dones=%0d pool=%0d", dones, jackpot_pool);
        doSpin("after_reset", 12'h552, 1'b0, 17'd1, 21, 2, 5010);

        // Grow the pool to just below the ceiling, then clamp it.
        spin_in = 12'h123; bet_max = 1'b1; score_in = 17'd0;
        runHeld(2521, dones, pattern);
        checkValue("grow dones", dones, 2521);
        checkValue("grow pool", 32'(jackpot_pool), 131060);
        $display("spin grow: dones=%0d pool=%0d", dones, jackpot_pool);
        doSpin("pool_clamp", 12'h123, 1'b1, 17'd9,   9,      0, 131071);
        doSpin("pool_hold",  12'h123, 1'b1, 17'd9,   9,      0, 131071);
        doSpin("jp_sat",     12'h777, 1'b0, 17'd100, 131071, 3, 5000);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
